serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fulladder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, LSB first, one bit per clock
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    // Holds the WIDTH-1 result bits produced before the final cycle; the
    // final bit joins them directly on the way into sum.
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_full;
    logic             fa_s;
    logic             fa_cout;

    fulladder u_fa (
        .A    (op_a[0]),
        .B    (op_b[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign last     = (cnt == CW'(WIDTH - 1));
    assign res_full = {fa_s, res};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: start is only honoured outside RUN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand load, serial shift/accumulate, result publish
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            res   <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_full[WIDTH-1:1];
                    carry <= fa_cout;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    if (last) begin
                        sum  <= res_full;
                        cout <= fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
